// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - operand entry sequencer feeding the sign-magnitude add/subtract unit

// button_conditioner: 2-flop synchronizer, counter debounce and rising-edge strobe.
//   clk, rst_n : clock and synchronous active-low reset
//   raw        : asynchronous active-high button level
//   pulse      : one-cycle strobe on each accepted press
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

    logic        sync_1;
    logic        sync_2;
    logic        level;
    logic        level_prev;
    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // The counter first reaches the limit after DEBOUNCE_CYCLES disagreeing
    // cycles; the level flips on the following edge, so a pulse must outlast
    // DEBOUNCE_CYCLES synchronized cycles to be accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= 1'b0;
            count <= 16'd0;
        end else if (sync_2 == level) begin
            count <= 16'd0;
        end else if (count == DB_LIMIT) begin
            level <= sync_2;
            count <= 16'd0;
        end else begin
            count <= count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign pulse = level & ~level_prev;

endmodule

// operand_sequencer: captures A, B and the operation over successive ENTER presses.
//   sw, op_sub_sw           : quasi-static switches, sampled only on capture edges
//   enter_btn, clear_btn    : raw push-buttons
//   num1, num2, selection   : registered operand set
//   operands_valid          : high while in S_RUN
//   state_dbg               : current state encoding
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       op_sub_sw,
    input  logic       enter_btn,
    input  logic       clear_btn,
    output logic [2:0] num1,
    output logic [2:0] num2,
    output logic       selection,
    output logic       operands_valid,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] num1_d;
    logic [2:0] num2_d;
    logic       selection_d;
    logic       valid_d;
    logic [2:0] sw_norm;
    logic       enter_pulse;
    logic       clear_pulse;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (enter_btn),
        .pulse (enter_pulse)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (clear_btn),
        .pulse (clear_pulse)
    );

    // Zero magnitude is always stored as +0 so the adder never sees -0.
    assign sw_norm = (sw[1:0] == 2'b00) ? 3'b000 : sw;

    always_comb begin
        state_d     = state_q;
        num1_d      = num1;
        num2_d      = num2;
        selection_d = selection;
        valid_d     = operands_valid;
        if (clear_pulse) begin
            // Clear has priority; a coincident enter is dropped.
            state_d     = S_A;
            num1_d      = 3'b000;
            num2_d      = 3'b000;
            selection_d = 1'b0;
            valid_d     = 1'b0;
        end else if (enter_pulse) begin
            case (state_q)
                S_A: begin
                    num1_d  = sw_norm;
                    state_d = S_B;
                end
                S_B: begin
                    num2_d  = sw_norm;
                    state_d = S_OP;
                end
                S_OP: begin
                    selection_d = op_sub_sw;
                    valid_d     = 1'b1;
                    state_d     = S_RUN;
                end
                S_RUN: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_A;
            num1           <= 3'b000;
            num2           <= 3'b000;
            selection      <= 1'b0;
            operands_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            num1           <= num1_d;
            num2           <= num2_d;
            selection      <= selection_d;
            operands_valid <= valid_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed self-checking bench for operand_sequencer
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sw;
    logic       op_sub_sw;
    logic       enter_btn;
    logic       clear_btn;
    logic [2:0] num1;
    logic [2:0] num2;
    logic       selection;
    logic       operands_valid;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw             (sw),
        .op_sub_sw      (op_sub_sw),
        .enter_btn      (enter_btn),
        .clear_btn      (clear_btn),
        .num1           (num1),
        .num2           (num2),
        .selection      (selection),
        .operands_valid (operands_valid),
        .state_dbg      (state_dbg)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int n);
        enter_btn = 1'b1;
        cycles(n);
        enter_btn = 1'b0;
        cycles(12);
    endtask

    initial begin
        logic [1:0] prev_state;
        int         trans;
        logic       moved;

        rst_n     = 1'b0;
        sw        = 3'b000;
        op_sub_sw = 1'b0;
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        cycles(2);
        check("rst_num1", 8'(num1), 8'd0);
        check("rst_num2", 8'(num2), 8'd0);
        check("rst_sel", 8'(selection), 8'd0);
        check("rst_valid", 8'(operands_valid), 8'd0);
        check("rst_state", 8'(state_dbg), 8'd0);
        rst_n = 1'b1;

        // Short glitch must be ignored
        moved = 1'b0;
        enter_btn = 1'b1;
        cycles(2);
        enter_btn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycles(1);
            if (state_dbg != 2'b00) moved = 1'b1;
        end
        check("glitch_no_move", 8'(moved), 8'd0);

        // Full entry sequence
        sw = 3'b011;
        press(10);
        check("a_state", 8'(state_dbg), 8'd1);
        sw = 3'b110;
        press(10);
        check("b_state", 8'(state_dbg), 8'd2);
        op_sub_sw = 1'b1;
        enter_btn = 1'b1;
        cycles(7);
        check("valid_before_lat", 8'(operands_valid), 8'd0);
        cycles(1);
        check("valid_at_lat", 8'(operands_valid), 8'd1);
        cycles(2);
        enter_btn = 1'b0;
        cycles(12);
        check("run_num1", 8'(num1), 8'd3);
        check("run_num2", 8'(num2), 8'd6);
        check("run_sel", 8'(selection), 8'd1);
        check("run_state", 8'(state_dbg), 8'd3);
        check("run_valid", 8'(operands_valid), 8'd1);

        // Frozen in S_RUN
        sw = 3'b101;
        cycles(10);
        check("frozen_num1", 8'(num1), 8'd3);
        check("frozen_num2", 8'(num2), 8'd6);
        press(10);
        check("exit_valid", 8'(operands_valid), 8'd0);
        check("exit_state", 8'(state_dbg), 8'd0);
        check("exit_num1", 8'(num1), 8'd3);

        // Negative zero normalization on both operands
        sw = 3'b100;
        press(10);
        check("negzero_num1", 8'(num1), 8'd0);
        press(10);
        check("negzero_num2", 8'(num2), 8'd0);
        op_sub_sw = 1'b1;
        press(10);
        check("second_run_state", 8'(state_dbg), 8'd3);
        press(10);
        sw = 3'b101;
        press(10);
        check("pre_clear_num1", 8'(num1), 8'd5);
        check("pre_clear_state", 8'(state_dbg), 8'd1);

        // Enter and clear together: clear wins
        moved = 1'b0;
        enter_btn = 1'b1;
        clear_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (state_dbg == 2'b10) moved = 1'b1;
        end
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycles(1);
            if (state_dbg == 2'b10) moved = 1'b1;
        end
        check("clear_no_op", 8'(moved), 8'd0);
        check("clear_state", 8'(state_dbg), 8'd0);
        check("clear_num1", 8'(num1), 8'd0);
        check("clear_sel", 8'(selection), 8'd0);
        check("clear_valid", 8'(operands_valid), 8'd0);

        // Long hold gives one capture
        sw = 3'b001;
        trans = 0;
        prev_state = state_dbg;
        enter_btn = 1'b1;
        for (int i = 0; i < 62; i++) begin
            if (i == 50) enter_btn = 1'b0;
            cycles(1);
            if (state_dbg != prev_state) trans++;
            prev_state = state_dbg;
        end
        check("hold_trans", 8'(trans), 8'd1);
        check("hold_state", 8'(state_dbg), 8'd1);
        check("hold_num1", 8'(num1), 8'd1);

        // Bouncing then stable high gives one capture
        sw = 3'b010;
        trans = 0;
        prev_state = state_dbg;
        enter_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enter_btn = ~enter_btn;
            for (int j = 0; j < 2; j++) begin
                cycles(1);
                if (state_dbg != prev_state) trans++;
                prev_state = state_dbg;
            end
        end
        enter_btn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 20) enter_btn = 1'b0;
            cycles(1);
            if (state_dbg != prev_state) trans++;
            prev_state = state_dbg;
        end
        check("bounce_trans", 8'(trans), 8'd1);
        check("bounce_state", 8'(state_dbg), 8'd2);
        check("bounce_num2", 8'(num2), 8'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Front-end entry stage directly upstream of the 3-bit sign-magnitude add/subtract unit.
- Collects two operands and the add/subtract choice from board switches over successive debounced ENTER presses, then holds them stable for the arithmetic stage.
- Drives the adder's operand A, operand B and subtract-select inputs, plus a valid flag that tells downstream display logic when the adder output is meaningful.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before a button level is accepted; legal range 1..65535 (board builds override it, e.g. 500000 is not legal, use ≤65535 with a prescaled clock).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- sw  input  3  operand switches, sign-magnitude: bit2 = sign (1 = negative), bits1:0 = magnitude
- op_sub_sw  input  1  operation switch: 1 = subtract, 0 = add
- enter_btn  input  1  raw ENTER push-button, asynchronous to clk, active-high
- clear_btn  input  1  raw CLEAR push-button, asynchronous to clk, active-high
- num1  output  3  captured operand A, sign-magnitude, registered
- num2  output  3  captured operand B, sign-magnitude, registered
- selection  output  1  captured operation, 1 = subtract, registered
- operands_valid  output  1  high while num1, num2 and selection form a complete operand set
- state_dbg  output  2  current FSM state encoding

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low; ports are named clk and rst_n.
  - rst_n low at a rising clk edge sets num1, num2, selection and operands_valid to 0 and state to S_A (state_dbg = 00).
  - The same reset clears synchronizer flops, debounced levels and debounce counters to 0.
  - Reset overrides all other activity, including a capture in progress.
- Synchronizers: enter_btn and clear_btn each pass through a 2-flop synchronizer.
- Debounce (per button):
  - A 16-bit counter increments each cycle that the synchronized level differs from the debounced level. It resets to 0 whenever the two levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter returns to 0.
  - Any pulse shorter than DEBOUNCE_CYCLES cycles after synchronization is ignored.
- Edge detect:
  - enter_pulse and clear_pulse are single-cycle rising-edge strobes of the debounced levels.
  - Latency from the first edge sampling a raw high to the strobe being high is DEBOUNCE_CYCLES + 3 cycles.
  - A button held high produces exactly one strobe. Release followed by a new press is required for another strobe.
- Negative zero: on any operand capture, if sw[1:0] == 00 the stored sign bit is forced to 0 (sw = 100 is stored as 000).
- FSM (state_dbg encoding):
  - S_A = 00: on enter_pulse, num1 <= normalized sw; go to S_B.
  - S_B = 01: on enter_pulse, num2 <= normalized sw; go to S_OP.
  - S_OP = 10: on enter_pulse, selection <= op_sub_sw; go to S_RUN.
  - S_RUN = 11: operands_valid = 1 and all outputs frozen. On enter_pulse go to S_A and set operands_valid <= 0. num1, num2 and selection keep their old values until overwritten.
- All captures and state changes take effect at the edge where the strobe is high; new values are visible the following cycle.
- operands_valid is registered: it rises on the same edge that enters S_RUN and falls on the edge that leaves S_RUN.
- Clear behaviour:
  - clear_pulse in any state sends the FSM to S_A and sets num1, num2, selection and operands_valid to 0.
  - If clear_pulse and enter_pulse are high in the same cycle, clear wins and the enter is discarded.
- Switch inputs are sampled only on capture edges and need no synchronizer; the switches are quasi-static and have changed well before the debounced ENTER strobe.
- Button held through reset release: the debounced level starts at 0, so the held button yields one strobe DEBOUNCE_CYCLES + 3 cycles after reset deasserts.

Test Plan:
- Reset with rst_n low for 2 cycles → num1 = 000, num2 = 000, selection = 0, operands_valid = 0, state_dbg = 00. Then hold enter_btn high for 2 cycles (DEBOUNCE_CYCLES = 4) → no strobe and state_dbg stays 00.
- sw = 011, press ENTER for 10 cycles; sw = 110, press; op_sub_sw = 1, press:
  - → num1 = 011, num2 = 110, selection = 1.
  - → operands_valid rises exactly 7 cycles after the third press's first sampled high; state_dbg = 11.
- In S_RUN, change sw to 101 without pressing → num1 and num2 unchanged. Press ENTER → operands_valid = 0, state_dbg = 00, num1 still 011.
- sw = 100 captured as operand A → num1 = 000 (sign cleared).
- In S_B, assert enter_btn and clear_btn together for 10 cycles → state_dbg = 00, num1 = 000, operands_valid = 0, no transition to S_OP.
- Hold enter_btn high for 50 cycles → exactly one capture. Bouncing input toggling every 2 cycles for 20 cycles, then stable high → one capture only.
